// File: rtl/seg7_scan_driver_if.sv
// Digit bus from the IO register block plus the scanned display drive back out.
// master = register block side, slave = scanner side.
interface seg7_scan_driver_if #(
    parameter int NDIG = 8
);
    logic                en;
    logic [3:0]          bright;
    logic [8*NDIG-1:0]   dgt;
    logic [7:0]          seg;
    logic [NDIG-1:0]     an;
    logic                frame;

    modport master (output en, bright, dgt, input seg, an, frame);
    modport slave  (input en, bright, dgt, output seg, an, frame);
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scanner: per digit a blank guard, then a PWM-gated anode phase.
// All outputs registered (1-cycle latency from state); no backpressure, en=0 darkens next cycle.
module seg7_scan_driver #(
    parameter int NDIG       = 8,
    parameter int DIV        = 4096,
    parameter int BLANK_CYC  = 64,
    parameter bit SEG_ACT_LO = 1'b1,
    parameter bit AN_ACT_LO  = 1'b1
) (
    input  logic Clk,
    input  logic Rst,
    seg7_scan_driver_if.slave bus
);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CW = $clog2(DIV + BLANK_CYC + 1);

    localparam logic [7:0]      SEG_OFF    = {8{SEG_ACT_LO}};
    localparam logic [NDIG-1:0] AN_OFF     = {NDIG{AN_ACT_LO}};
    localparam logic [CW-1:0]   STEP       = CW'(DIV / 16);
    localparam logic [CW-1:0]   BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0]   ON_LAST    = CW'(DIV - 1);
    localparam logic [IW-1:0]   IDX_LAST   = IW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

    state_t            state;
    logic [IW-1:0]     idx;
    logic [CW-1:0]     cnt;
    logic [8*NDIG-1:0] snap;
    logic [3:0]        duty;

    logic [CW-1:0]     thr;
    logic [CW-1:0]     cnt_inc;
    logic [7:0]        seg_on;
    logic [NDIG-1:0]   an_on;

    // Anode stays lit while the ON counter is below (duty+1)/16 of the phase.
    assign thr     = (CW'(duty) + CW'(1)) * STEP;
    assign cnt_inc = cnt + CW'(1);
    assign seg_on  = snap[{idx, 3'b000} +: 8] ^ SEG_OFF;
    assign an_on   = (NDIG'(1) << idx) ^ AN_OFF;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            snap      <= '0;
            duty      <= '0;
            bus.seg   <= SEG_OFF;
            bus.an    <= AN_OFF;
            bus.frame <= 1'b0;
        end else begin
            bus.frame <= 1'b0;
            if (!bus.en) begin
                state   <= IDLE;
                idx     <= '0;
                cnt     <= '0;
                bus.seg <= SEG_OFF;
                bus.an  <= AN_OFF;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= BLANK;
                        idx       <= '0;
                        cnt       <= '0;
                        snap      <= bus.dgt;
                        duty      <= bus.bright;
                        bus.frame <= 1'b1;
                        bus.seg   <= SEG_OFF;
                        bus.an    <= AN_OFF;
                    end
                    BLANK: begin
                        if (cnt == BLANK_LAST) begin
                            state   <= ON;
                            cnt     <= '0;
                            bus.seg <= seg_on;
                            bus.an  <= an_on;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    ON: begin
                        if (cnt == ON_LAST) begin
                            state   <= BLANK;
                            cnt     <= '0;
                            duty    <= bus.bright;
                            bus.seg <= SEG_OFF;
                            bus.an  <= AN_OFF;
                            // Snapshot only at frame wrap so a frame is never torn.
                            if (idx == IDX_LAST) begin
                                idx       <= '0;
                                snap      <= bus.dgt;
                                bus.frame <= 1'b1;
                            end else begin
                                idx <= idx + IW'(1);
                            end
                        end else begin
                            cnt     <= cnt_inc;
                            bus.seg <= seg_on;
                            bus.an  <= (cnt_inc < thr) ? an_on : AN_OFF;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        bus.seg <= SEG_OFF;
                        bus.an  <= AN_OFF;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: expected per-cycle drive queued from the display timeline.
module tb_seg7_scan_driver;
    localparam int NDIG      = 8;
    localparam int DIV       = 32;
    localparam int BLANK_CYC = 2;
    localparam int SLOT      = BLANK_CYC + DIV;
    localparam int FRAME     = NDIG * SLOT;

    localparam logic [63:0] PAT_A = 64'h8040201008040201;
    localparam logic [63:0] PAT_B = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] PAT_C = 64'h0123_4567_89AB_CDEF;

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] seg;
        logic       frame;
    } exp_t;

    localparam exp_t DARK = '{an: 8'hFF, seg: 8'hFF, frame: 1'b0};

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    seg7_scan_driver_if #(.NDIG(NDIG)) bus ();

    seg7_scan_driver #(
        .NDIG(NDIG), .DIV(DIV), .BLANK_CYC(BLANK_CYC),
        .SEG_ACT_LO(1'b1), .AN_ACT_LO(1'b1)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;
    int   act_len[NDIG];

    task automatic chk(input string tag, input exp_t got, input exp_t exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed an=%h seg=%h frame=%b expected an=%h seg=%h frame=%b",
                   tag, got.an, got.seg, got.frame, exp.an, exp.seg, exp.frame);
        end
    endtask

    task automatic set_bright_all(input int b);
        for (int k = 0; k < NDIG; k++) act_len[k] = (b + 1) * (DIV / 16);
    endtask

    // Expected drive for frame positions first..last, bytes d, anode lengths act_len.
    task automatic push_range(input logic [63:0] d, input int first, input int last);
        exp_t e;
        int   s;
        int   o;
        for (int p = first; p <= last; p++) begin
            s = p / SLOT;
            o = p % SLOT;
            e.frame = (p == 0);
            if (o < BLANK_CYC) begin
                e.an  = 8'hFF;
                e.seg = 8'hFF;
            end else begin
                e.seg = ~d[8*s +: 8];
                e.an  = ((o - BLANK_CYC) < act_len[s]) ? ~(8'h01 << s) : 8'hFF;
            end
            q.push_back(e);
        end
    endtask

    task automatic push_dark(input int n);
        for (int i = 0; i < n; i++) q.push_back(DARK);
    endtask

    task automatic run_check(input string tag, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL %s scoreboard empty at cycle %0d", tag, i);
            end else begin
                e = q.pop_front();
                chk(tag, {bus.an, bus.seg, bus.frame}, e);
            end
        end
    endtask

    initial begin
        Rst        = 1'b1;
        bus.en     = 1'b1;
        bus.bright = 4'd15;
        bus.dgt    = PAT_A;

        // Reset holds everything dark even with en asserted.
        push_dark(3);
        run_check("reset", 3);

        // Full brightness frame, then the next frame shows the regular 272-cycle period.
        set_bright_all(15);
        push_range(PAT_A, 0, FRAME - 1);
        Rst = 1'b0;
        run_check("frame_b15", FRAME);

        bus.bright = 4'd3;
        set_bright_all(3);
        push_range(PAT_A, 0, FRAME - 1);
        run_check("bright3", FRAME);

        // bright=0, and new digit data mid-frame must wait for the next frame.
        bus.bright = 4'd0;
        set_bright_all(0);
        push_range(PAT_A, 0, FRAME - 1);
        run_check("dgt_mid_old", 3 * SLOT + 10);
        bus.dgt = PAT_B;
        run_check("dgt_mid_old", FRAME - 3 * SLOT - 10);

        // Brightness changed during digit 2 ON applies from digit 3 onward.
        set_bright_all(0);
        for (int k = 3; k < NDIG; k++) act_len[k] = DIV;
        push_range(PAT_B, 0, FRAME - 1);
        run_check("bright_mid", 2 * SLOT + 10);
        bus.bright = 4'd15;
        run_check("bright_mid", FRAME - 2 * SLOT - 10);

        // Disable during digit 5 ON, then re-enable with fresh data.
        set_bright_all(15);
        push_range(PAT_B, 0, 5 * SLOT + BLANK_CYC + 9);
        run_check("pre_disable", 5 * SLOT + BLANK_CYC + 10);
        bus.en = 1'b0;
        push_dark(3);
        run_check("disabled", 3);
        bus.dgt = PAT_C;
        bus.en  = 1'b1;
        push_range(PAT_C, 0, 2 * SLOT - 1);
        run_check("reenable", 2 * SLOT);

        // Async reset between clock edges during digit 2 ON.
        push_range(PAT_C, 2 * SLOT, 2 * SLOT + BLANK_CYC + 4);
        run_check("pre_async", BLANK_CYC + 5);
        #2;
        Rst = 1'b1;
        #1;
        chk("async_rst", {bus.an, bus.seg, bus.frame}, DARK);
        push_dark(2);
        run_check("async_hold", 2);
        Rst = 1'b0;
        push_range(PAT_C, 0, SLOT - 1);
        run_check("after_rst", SLOT);

        checks++;
        assert (q.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard_drain observed %0d left expected 0", q.size());
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
